// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - SPI ADC responder emulating an 8-channel 12-bit converter
// Oversamples SCLK/CS_N/SADDR on clk and answers each 16-clock frame with injected channel data.
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int NUM_CH      = 8,
   parameter int LEAD_ZEROS  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W*NUM_CH-1:0]   ch_data,
   input  logic                       adc_sclk,
   input  logic                       adc_cs_n,
   input  logic                       adc_saddr,
   output logic                       adc_sdat,
   output logic                       adc_sdat_oe,
   output logic [$clog2(NUM_CH)-1:0]  cur_ch,
   output logic                       frame_done,
   output logic                       frame_abort
);

   localparam int ADDR_W     = $clog2(NUM_CH);
   localparam int FRAME_BITS = DATA_W + LEAD_ZEROS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int ADDR_RISE  = 3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ACTIVE    = 2'd1;
   localparam logic [1:0] ST_WAIT_NEXT = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, saddr_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, saddr_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   logic [1:0]             state;
   logic [FRAME_BITS-1:0]  shreg;
   logic [CNT_W-1:0]       rise_cnt;
   logic [ADDR_W-1:0]      addr_sr;
   logic [ADDR_W-1:0]      next_addr;
   logic [DATA_W-1:0]      sel_sample;
   logic                   do_load;

   // Synchronizers reset to the idle bus levels so no spurious edge follows reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync  <= '1;
         cs_sync    <= '1;
         saddr_sync <= '0;
         sclk_d     <= 1'b1;
         cs_d       <= 1'b1;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
         cs_sync    <= {cs_sync[SYNC_STAGES-2:0], adc_cs_n};
         saddr_sync <= {saddr_sync[SYNC_STAGES-2:0], adc_saddr};
         sclk_d     <= sclk_s;
         cs_d       <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign saddr_s   = saddr_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   always_comb begin
      sel_sample = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (next_addr == ADDR_W'(i)) sel_sample = ch_data[DATA_W*i +: DATA_W];
      end
   end

   // A new frame starts on CS fall, or on the first SCLK fall after a completed frame with CS held low.
   always_comb begin
      do_load = 1'b0;
      if (state == ST_IDLE && cs_fall) do_load = 1'b1;
      if (state == ST_WAIT_NEXT && sclk_fall && !cs_s) do_load = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         adc_sdat_oe <= 1'b0;
         cur_ch      <= '0;
         next_addr   <= '0;
         addr_sr     <= '0;
         rise_cnt    <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         if (cs_rise) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            adc_sdat_oe <= 1'b0;
            if (state == ST_ACTIVE) frame_abort <= 1'b1;
         end else if (do_load) begin
            state       <= ST_ACTIVE;
            cur_ch      <= next_addr;
            shreg       <= {{LEAD_ZEROS{1'b0}}, sel_sample};
            adc_sdat_oe <= 1'b1;
            rise_cnt    <= '0;
         end else if (state == ST_ACTIVE) begin
            if (sclk_fall) begin
               shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end else if (sclk_rise) begin
               rise_cnt <= rise_cnt + CNT_W'(1);
               if (rise_cnt >= CNT_W'(ADDR_RISE-1) && rise_cnt < CNT_W'(ADDR_RISE-1+ADDR_W))
                  addr_sr <= ADDR_W'({addr_sr, saddr_s});
               if (rise_cnt == CNT_W'(FRAME_BITS-1)) begin
                  next_addr  <= addr_sr;
                  frame_done <= 1'b1;
                  state      <= ST_WAIT_NEXT;
               end
            end
         end
      end
   end

   assign adc_sdat = shreg[FRAME_BITS-1];

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed vector bench for adc_spi_responder
module tb_adc_spi_responder;

   logic        clk;
   logic        reset;
   logic [95:0] ch_data;
   logic        adc_sclk, adc_cs_n, adc_saddr;
   logic        adc_sdat, adc_sdat_oe;
   logic [2:0]  cur_ch;
   logic        frame_done, frame_abort;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   adc_spi_responder dut (
      .clk         (clk),
      .reset       (reset),
      .ch_data     (ch_data),
      .adc_sclk    (adc_sclk),
      .adc_cs_n    (adc_cs_n),
      .adc_saddr   (adc_saddr),
      .adc_sdat    (adc_sdat),
      .adc_sdat_oe (adc_sdat_oe),
      .cur_ch      (cur_ch),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_abort) abort_cnt++;
   end

   typedef struct {
      logic [2:0]  addr;
      int          nrise;
      bit          b2b;
      bit          cs_end;
      logic [15:0] exp_dout;
      logic [2:0]  exp_ch;
      int          exp_done;
      int          exp_abort;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // SCLK half period is 4 clk; bit k is sampled after falling edge k (k-1 in a back-to-back frame).
   task automatic run_frame(input logic [2:0] addr, input int nrise, input bit b2b, input bit cs_end,
                            input int chg_at, input logic [11:0] chg_val, input int rst_at,
                            output logic [15:0] dout, output logic [2:0] ch);
      int st;
      dout = '0;
      ch   = '0;
      if (!b2b) begin
         adc_cs_n = 1'b0;
         wait_clk(4);
         dout[15] = adc_sdat;
         ch = cur_ch;
      end
      for (int k = 1; k <= nrise; k++) begin
         adc_sclk  = 1'b0;
         adc_saddr = (k >= 3 && k <= 5) ? addr[5-k] : 1'b0;
         wait_clk(4);
         st = b2b ? k - 1 : k;
         if (st <= 15) dout[15-st] = adc_sdat;
         if (st == 0) ch = cur_ch;
         if (k == chg_at) ch_data[11:0] = chg_val;
         if (k == rst_at) begin
            check("pre-reset oe", {31'b0, adc_sdat_oe}, 32'd1);
            reset = 1'b1;
            #1;
            check("reset sdat", {31'b0, adc_sdat}, 32'd0);
            check("reset oe", {31'b0, adc_sdat_oe}, 32'd0);
            check("reset cur_ch", {29'b0, cur_ch}, 32'd0);
            adc_cs_n  = 1'b1;
            adc_sclk  = 1'b1;
            adc_saddr = 1'b0;
            wait_clk(4);
            reset = 1'b0;
            wait_clk(4);
            return;
         end
         adc_sclk = 1'b1;
         wait_clk(4);
      end
      adc_saddr = 1'b0;
      if (cs_end) begin
         adc_cs_n = 1'b1;
         wait_clk(6);
      end
   endtask

   initial begin
      logic [15:0] dout;
      logic [2:0]  ch;
      int          d0, a0;

      vecs[0]  = '{3'd5, 16, 1'b0, 1'b1, 16'h0ABC, 3'd0, 1, 0};
      vecs[1]  = '{3'd0, 16, 1'b0, 1'b1, 16'h05A5, 3'd5, 1, 0};
      vecs[2]  = '{3'd1, 16, 1'b0, 1'b1, 16'h0ABC, 3'd0, 1, 0};
      vecs[3]  = '{3'd2, 16, 1'b0, 1'b1, 16'h0111, 3'd1, 1, 0};
      vecs[4]  = '{3'd3, 16, 1'b0, 1'b1, 16'h0222, 3'd2, 1, 0};
      vecs[5]  = '{3'd4, 16, 1'b0, 1'b1, 16'h0123, 3'd3, 1, 0};
      vecs[6]  = '{3'd5, 16, 1'b0, 1'b1, 16'h04C4, 3'd4, 1, 0};
      vecs[7]  = '{3'd6, 16, 1'b0, 1'b1, 16'h05A5, 3'd5, 1, 0};
      vecs[8]  = '{3'd7, 16, 1'b0, 1'b1, 16'h0FED, 3'd6, 1, 0};
      vecs[9]  = '{3'd3, 16, 1'b0, 1'b0, 16'h0777, 3'd7, 1, 0};
      vecs[10] = '{3'd6, 16, 1'b1, 1'b0, 16'h0123, 3'd3, 1, 0};
      vecs[11] = '{3'd0, 16, 1'b1, 1'b1, 16'h0FED, 3'd6, 1, 0};
      vecs[12] = '{3'd7,  9, 1'b0, 1'b1, 16'h0A80, 3'd0, 0, 1};
      vecs[13] = '{3'd2, 16, 1'b0, 1'b1, 16'h0ABC, 3'd0, 1, 0};

      ch_data = {12'h777, 12'hFED, 12'h5A5, 12'h4C4, 12'h123, 12'h222, 12'h111, 12'hABC};
      adc_sclk  = 1'b1;
      adc_cs_n  = 1'b1;
      adc_saddr = 1'b0;
      reset     = 1'b1;
      wait_clk(3);
      check("rst sdat", {31'b0, adc_sdat}, 32'd0);
      check("rst oe", {31'b0, adc_sdat_oe}, 32'd0);
      check("rst cur_ch", {29'b0, cur_ch}, 32'd0);
      check("rst done", {31'b0, frame_done}, 32'd0);
      check("rst abort", {31'b0, frame_abort}, 32'd0);
      reset = 1'b0;
      wait_clk(4);

      for (int i = 0; i < 14; i++) begin
         d0 = done_cnt;
         a0 = abort_cnt;
         run_frame(vecs[i].addr, vecs[i].nrise, vecs[i].b2b, vecs[i].cs_end, 0, 12'h000, 0, dout, ch);
         check($sformatf("v%0d dout", i), {16'b0, dout}, {16'b0, vecs[i].exp_dout});
         check($sformatf("v%0d cur_ch", i), {29'b0, ch}, {29'b0, vecs[i].exp_ch});
         check($sformatf("v%0d done", i), done_cnt - d0, vecs[i].exp_done);
         check($sformatf("v%0d abort", i), abort_cnt - a0, vecs[i].exp_abort);
         check($sformatf("v%0d oe", i), {31'b0, adc_sdat_oe}, {31'b0, !vecs[i].cs_end});
      end

      // Mid-frame ch_data change must not disturb the captured sample.
      ch_data[11:0] = 12'h800;
      run_frame(3'd0, 16, 1'b0, 1'b1, 0, 12'h000, 0, dout, ch);
      check("seq ch2 dout", {16'b0, dout}, 32'h0222);
      run_frame(3'd4, 16, 1'b0, 1'b1, 6, 12'h7FF, 0, dout, ch);
      check("chg dout", {16'b0, dout}, 32'h0800);
      check("chg cur_ch", {29'b0, ch}, 32'd0);

      // Reset in the middle of a frame on channel 4.
      d0 = done_cnt;
      a0 = abort_cnt;
      run_frame(3'd1, 16, 1'b0, 1'b1, 0, 12'h000, 8, dout, ch);
      check("rstmid cur_ch", {29'b0, ch}, 32'd4);
      check("rstmid bits", {23'b0, dout[15:7]}, 32'b000001001);
      check("rstmid done", done_cnt - d0, 32'd0);
      check("rstmid abort", abort_cnt - a0, 32'd0);

      d0 = done_cnt;
      run_frame(3'd2, 16, 1'b0, 1'b1, 0, 12'h000, 0, dout, ch);
      check("post-rst dout", {16'b0, dout}, 32'h07FF);
      check("post-rst cur_ch", {29'b0, ch}, 32'd0);
      check("post-rst done", done_cnt - d0, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
